// File: rtl/mips_cpu_muldiv_ctrl_if.sv
// CPU <-> multiply/divide unit bus: operation request, HI/LO moves and status.
interface mips_cpu_muldiv_ctrl_if;
  localparam int unsigned W = 32;

  logic         start;
  logic [1:0]   op;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         mthi;
  logic         mtlo;
  logic         mf_req;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         busy;
  logic         done;
  logic         stall;

  modport master (
    output start, op, op_a, op_b, mthi, mtlo, mf_req,
    input  hi, lo, busy, done, stall
  );

  modport slave (
    input  start, op, op_a, op_b, mthi, mtlo, mf_req,
    output hi, lo, busy, done, stall
  );
endinterface

// File: rtl/mips_cpu_muldiv_ctrl.sv
// Sequential MULT/MULTU/DIV/DIVU engine owning HI/LO, with MTHI/MTLO and
// a CPU stall while a result is pending.
module mips_cpu_muldiv_ctrl #(
  parameter int unsigned ITER = 32
) (
  input logic                    clk,
  input logic                    reset,
  input logic                    clk_enable,
  mips_cpu_muldiv_ctrl_if.slave  bus
);
  localparam int unsigned W  = 32;
  localparam int unsigned CW = $clog2(ITER);

  typedef enum logic [1:0] {IDLE, RUN, FIXUP} state_t;

  state_t         state;
  logic [CW-1:0]  count;
  logic [1:0]     op_q;
  logic           neg_q;
  logic           neg_r;
  logic [W-1:0]   mag_a;
  logic [W-1:0]   mag_b;
  logic [2*W-1:0] prod;
  logic [W-1:0]   quo;
  logic [W-1:0]   rem;
  logic [W-1:0]   hi;
  logic [W-1:0]   lo;
  logic           busy;
  logic           done;

  logic           in_signed;
  logic [W-1:0]   in_mag_a;
  logic [W-1:0]   in_mag_b;
  logic [W:0]     mul_sum;
  logic [W:0]     div_shift;
  logic           div_ge;
  logic [W-1:0]   div_diff;
  logic [2*W-1:0] fix_prod;
  logic [W-1:0]   fix_quo;
  logic [W-1:0]   fix_rem;

  // Operand magnitudes, one engine step and the final sign correction.
  always_comb begin
    in_signed = ~bus.op[0];
    in_mag_a  = (in_signed && bus.op_a[W-1]) ? -bus.op_a : bus.op_a;
    in_mag_b  = (in_signed && bus.op_b[W-1]) ? -bus.op_b : bus.op_b;

    mul_sum   = {1'b0, prod[2*W-1:W]} + {1'b0, (prod[0] ? mag_a : W'(0))};

    // The shifted-out bit W makes the partial remainder larger than any divisor.
    div_shift = {rem, quo[W-1]};
    div_ge    = div_shift[W] | (div_shift[W-1:0] >= mag_b);
    div_diff  = div_shift[W-1:0] - mag_b;

    fix_prod  = neg_q ? -prod : prod;
    fix_quo   = neg_q ? -quo  : quo;
    fix_rem   = neg_r ? -rem  : rem;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      count <= '0;
      op_q  <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      mag_a <= '0;
      mag_b <= '0;
      prod  <= '0;
      quo   <= '0;
      rem   <= '0;
      hi    <= '0;
      lo    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else if (clk_enable) begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_q  <= bus.op;
            neg_q <= in_signed & (bus.op_a[W-1] ^ bus.op_b[W-1]);
            neg_r <= in_signed & bus.op_a[W-1];
            mag_a <= in_mag_a;
            mag_b <= in_mag_b;
            prod  <= {W'(0), in_mag_b};
            quo   <= in_mag_a;
            rem   <= '0;
            count <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            if (bus.mthi) hi <= bus.op_a;
            if (bus.mtlo) lo <= bus.op_a;
          end
        end
        RUN: begin
          if (op_q[1]) begin
            rem <= div_ge ? div_diff : div_shift[W-1:0];
            quo <= {quo[W-2:0], div_ge};
          end else begin
            prod <= {mul_sum, prod[W-1:1]};
          end
          count <= CW'(count + CW'(1));
          if (count == CW'(ITER - 1)) state <= FIXUP;
        end
        FIXUP: begin
          if (op_q[1]) begin
            hi <= fix_rem;
            lo <= fix_quo;
          end else begin
            hi <= fix_prod[2*W-1:W];
            lo <= fix_prod[W-1:0];
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.hi    = hi;
  assign bus.lo    = lo;
  assign bus.busy  = busy;
  assign bus.done  = done;
  assign bus.stall = busy & (bus.start | bus.mf_req | bus.mthi | bus.mtlo);
endmodule

// File: tb/tb_mips_cpu_muldiv_ctrl.sv
// Self-checking bench for mips_cpu_muldiv_ctrl: vector table, random ops
// through a result scoreboard, and hand-written reset/stall/enable sequences.
module tb_mips_cpu_muldiv_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic clk_enable = 1'b1;

  always #5 clk = ~clk;

  mips_cpu_muldiv_ctrl_if bus ();

  mips_cpu_muldiv_ctrl #(.ITER(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .clk_enable (clk_enable),
    .bus        (bus)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  res_t        exp_q[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference result from the architectural definition of each op.
  function automatic res_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    res_t        r;
    logic        sgn;
    logic [63:0] p;
    logic [31:0] ma, mb, q, rm;
    sgn = ~op[0];
    if (!op[1]) begin
      p = {{32{a[31] & sgn}}, a} * {{32{b[31] & sgn}}, b};
      r.hi = p[63:32];
      r.lo = p[31:0];
    end else begin
      ma = (sgn && a[31]) ? -a : a;
      mb = (sgn && b[31]) ? -b : b;
      if (mb == 0) begin
        q  = 32'hFFFF_FFFF;
        rm = ma;
      end else begin
        q  = ma / mb;
        rm = ma % mb;
      end
      if (sgn && (a[31] ^ b[31])) q = -q;
      if (sgn && a[31]) rm = -rm;
      r.hi = rm;
      r.lo = q;
    end
    return r;
  endfunction

  // One operation from start to done; optional enable gap, busy poke, move-with-start.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input res_t e, input int ce_at, input int ce_len,
                        input int poke_at, input bit move);
    int   n;
    int   busy_n;
    res_t got;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.op_a  = a;
    bus.op_b  = b;
    bus.mtlo  = move;
    exp_q.push_back(e);
    #1 check("stall_idle", 64'(bus.stall), 64'(0));
    @(negedge clk);
    bus.start = 1'b0;
    bus.mtlo  = 1'b0;
    n = 1;
    busy_n = 0;
    forever begin
      if (n == poke_at) begin
        bus.start  = 1'b1;
        bus.mf_req = 1'b1;
        bus.mthi   = 1'b1;
        bus.op     = DIVU;
        #1 check("stall_busy", 64'(bus.stall), 64'(1));
      end
      if (n == poke_at + 1) begin
        bus.start  = 1'b0;
        bus.mf_req = 1'b0;
        bus.mthi   = 1'b0;
      end
      if (n == 4 && poke_at != 4) #1 check("stall_quiet", 64'(bus.stall), 64'(0));
      if (n == ce_at) clk_enable = 1'b0;
      if (n == ce_at + ce_len) clk_enable = 1'b1;
      if (n == 12) begin
        check("hold_hi", 64'(bus.hi), 64'(m_hi));
        check("hold_lo", 64'(bus.lo), 64'(m_lo));
      end
      busy_n += int'(bus.busy);
      if (bus.done || n >= 200) break;
      @(negedge clk);
      n++;
    end
    clk_enable = 1'b1;
    check("latency", 64'(n), 64'(34 + ce_len));
    check("busy_cycles", 64'(busy_n), 64'(33 + ce_len));
    if (!bus.done) begin
      check("done_timeout", 64'(0), 64'(1));
    end else if (exp_q.size() == 0) begin
      check("sb_empty", 64'(0), 64'(1));
    end else begin
      got = exp_q.pop_front();
      check("res_hi", 64'(bus.hi), 64'(got.hi));
      check("res_lo", 64'(bus.lo), 64'(got.lo));
      m_hi = got.hi;
      m_lo = got.lo;
    end
    @(negedge clk);
    check("done_pulse", 64'(bus.done), 64'(0));
    check("busy_idle", 64'(bus.busy), 64'(0));
  endtask

  vec_t vecs[10];

  initial begin
    int   n;
    int   done_seen;
    res_t r;
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    vecs[0] = '{MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1] = '{MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[2] = '{DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{DIVU,  32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF};
    vecs[4] = '{DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[5] = '{DIV,   32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF};
    vecs[6] = '{DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'h0000_0001};
    vecs[7] = '{MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[8] = '{DIVU,  32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF};
    vecs[9] = '{DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};

    bus.start  = 1'b0;
    bus.op     = MULT;
    bus.op_a   = '0;
    bus.op_b   = '0;
    bus.mthi   = 1'b0;
    bus.mtlo   = 1'b0;
    bus.mf_req = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_hi", 64'(bus.hi), 64'(0));
    check("rst_lo", 64'(bus.lo), 64'(0));
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_done", 64'(bus.done), 64'(0));
    reset = 1'b1;

    // MTHI alone, then MTHI and MTLO together.
    @(negedge clk);
    bus.mthi = 1'b1;
    bus.op_a = 32'h1234_5678;
    @(negedge clk);
    bus.mthi = 1'b0;
    check("mthi_hi", 64'(bus.hi), 64'(32'h1234_5678));
    check("mthi_lo", 64'(bus.lo), 64'(0));
    bus.mthi = 1'b1;
    bus.mtlo = 1'b1;
    bus.op_a = 32'hCAFE_F00D;
    @(negedge clk);
    bus.mthi = 1'b0;
    bus.mtlo = 1'b0;
    check("mthilo_hi", 64'(bus.hi), 64'(32'hCAFE_F00D));
    check("mthilo_lo", 64'(bus.lo), 64'(32'hCAFE_F00D));
    m_hi = 32'hCAFE_F00D;
    m_lo = 32'hCAFE_F00D;

    // MULTU 2*3 with a second start, mf_req and mthi presented while busy.
    r = '{32'h0, 32'h6};
    run_op(MULTU, 32'd2, 32'd3, r, 0, 0, 5, 1'b0);

    for (int i = 0; i < 10; i++) begin
      r = '{vecs[i].hi, vecs[i].lo};
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, r, 0, 0, 0, i == 2);
    end

    for (int i = 0; i < 8; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = (i % 2 == 0) ? $urandom : 32'($urandom_range(0, 40));
      run_op(rop, ra, rb, model(rop, ra, rb), 0, 0, 0, 1'b0);
    end

    // Reset in the middle of a DIVU aborts it and clears HI/LO.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = DIVU;
    bus.op_a  = 32'd10;
    bus.op_b  = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    n = 1;
    done_seen = 0;
    while (n < 12) begin
      @(negedge clk);
      n++;
    end
    reset = 1'b0;
    #1;
    check("abort_busy", 64'(bus.busy), 64'(0));
    check("abort_hi", 64'(bus.hi), 64'(0));
    check("abort_lo", 64'(bus.lo), 64'(0));
    check("abort_done", 64'(bus.done), 64'(0));
    repeat (2) @(negedge clk);
    reset = 1'b1;
    m_hi = '0;
    m_lo = '0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      done_seen += int'(bus.done) + int'(bus.busy);
    end
    check("abort_no_resume", 64'(done_seen), 64'(0));

    r = '{32'h0, 32'd20};
    run_op(MULTU, 32'd4, 32'd5, r, 0, 0, 0, 1'b0);

    // clk_enable low for five cycles mid-run stretches latency by five.
    r = '{32'h0, 32'd42};
    run_op(MULTU, 32'd6, 32'd7, r, 10, 5, 0, 1'b0);

    check("sb_drained", 64'(exp_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mips_cpu_muldiv_ctrl.md
Name: mips_cpu_muldiv_ctrl

Overview:
- Sequential multiply/divide unit with HI/LO ownership for the Harvard MIPS core; replaces the combinational `*`, `/` and `%` in the CPU datapath.
- Accepts MULT, MULTU, DIV and DIVU from the decode stage, runs a 32-iteration shift-add or restoring-divide engine, and writes HI/LO on completion.
- Also services MTHI/MTLO writes and MFHI/MFLO reads, and produces a stall so the CPU holds its PC and IR while a result is pending.

Parameters:
- ITER, 32, number of iteration cycles per operation; equals operand width; fixed at 32 for this core.

Ports:
- clk in 1: rising-edge clock.
- reset in 1: asynchronous, active-low reset.
- clk_enable in 1: when low, all state (FSM, counter, datapath, HI/LO) holds.
- start in 1: operation request, sampled only in IDLE.
- op in 2: 00=MULT, 01=MULTU, 10=DIV, 11=DIVU; sampled with start.
- op_a in 32: rs operand.
- op_b in 32: rt operand.
- mthi in 1: write op_a to HI.
- mtlo in 1: write op_a to LO.
- mf_req in 1: CPU is executing MFHI or MFLO this cycle.
- hi out 32: HI register.
- lo out 32: LO register.
- busy out 1: engine is not in IDLE.
- done out 1: one-cycle pulse when HI/LO are updated from an operation.
- stall out 1: combinational; equals busy & (start | mf_req | mthi | mtlo).

Behaviour:
- Reset (async, reset=0): state=IDLE, count=0, hi=0, lo=0, busy=0, done=0, internal accumulators=0.
- Reset mid-operation aborts the operation; HI/LO return to 0.
- All state changes require clk_enable=1.
- FSM states: IDLE, RUN, FIXUP.
- IDLE:
  - start=1 latches op, op_a and op_b.
  - For signed ops, latches the operand magnitudes plus sign flags: neg_q = sign(a)^sign(b), neg_r = sign(a).
  - Clears count and goes to RUN.
  - If start and mthi/mtlo are high together, start wins and the move is dropped.
- RUN, one iteration per enabled edge; count increments; at count==ITER-1 go to FIXUP.
  - Multiply: 64-bit product register, LSB-first shift-add of the unsigned magnitudes.
  - Divide: restoring algorithm; 33-bit partial remainder; shift in the dividend MSB-first; subtract divisor; set quotient bit if result ≥0, else restore.
- FIXUP (1 cycle):
  - Signed ops: negate the product if neg_q; negate the quotient if neg_q; negate the remainder if neg_r.
  - MULT/MULTU: hi=product[63:32], lo=product[31:0].
  - DIV/DIVU: lo=quotient, hi=remainder.
  - Register done=1 for the following cycle; return to IDLE.
- Latency: start accepted at edge E0; RUN occupies E1..E32; FIXUP at E33 writes HI/LO. done is high in the cycle after E33, and busy falls at E33.
- busy=1 from E0 until E33.
- Divide by zero produces no exception. The engine yields q=0xFFFFFFFF and r=|a|, and sign fixup then applies as usual.
- MIN_INT / -1 gives q=0x80000000, r=0 (naturally, through 32-bit wrap).
- start while busy: ignored, and stall is asserted; the CPU must re-present the request.
- mthi/mtlo in IDLE: write the register at the next edge; same-cycle mthi and mtlo are both honoured.
- mthi/mtlo while busy: ignored, with stall asserted.
- hi and lo are never modified during RUN; they hold the previous values until FIXUP.
- clk_enable=0 during RUN freezes count, so latency extends by exactly the number of disabled cycles.

Test Plan:
- MULTU op_a=0xFFFFFFFF, op_b=0xFFFFFFFF -> done exactly 34 cycles after start; hi=0xFFFFFFFE, lo=0x00000001; busy high 33 cycles.
- MULT op_a=0xFFFFFFFD (-3), op_b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV op_a=0xFFFFFFF9 (-7), op_b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; then DIVU 100/0 -> lo=0xFFFFFFFF, hi=0x00000064.
- MTHI op_a=0x12345678 in IDLE -> hi=0x12345678 next edge. Then start MULTU 2*3 and assert mf_req and a second start at cycle 5 -> stall=1, second start ignored, final lo=6, hi=0.
- Start DIVU 10/3, pull reset low at cycle 12 -> immediately busy=0, hi=lo=0, done never pulses. After release, MULTU 4*5 -> lo=20.
- MULTU 6*7 with clk_enable low for 5 cycles during RUN -> done at 39 cycles after start, lo=42, hi=0.
